// File: rtl/guess_pkg.sv
// Shared constants and charset helpers for the brute-force candidate generator.
package guess_pkg;

  localparam int MAXLEN = 16;

  localparam logic [2:0] CS_LOWER  = 3'd0;
  localparam logic [2:0] CS_UPPER  = 3'd1;
  localparam logic [2:0] CS_DIGIT  = 3'd2;
  localparam logic [2:0] CS_LOWDIG = 3'd3;
  localparam logic [2:0] CS_ALPHA  = 3'd4;
  localparam logic [2:0] CS_ALNUM  = 3'd5;
  localparam logic [2:0] CS_PRINT  = 3'd6;

  function automatic logic [6:0] cs_size(input logic [2:0] code);
    case (code)
      CS_UPPER:  return 7'd26;
      CS_DIGIT:  return 7'd10;
      CS_LOWDIG: return 7'd36;
      CS_ALPHA:  return 7'd52;
      CS_ALNUM:  return 7'd62;
      CS_PRINT:  return 7'd95;
      default:   return 7'd26;
    endcase
  endfunction

  // Code 7 is reserved and falls through to the lowercase set.
  function automatic logic [7:0] cs_char(input logic [2:0] code, input logic [6:0] idx);
    logic [7:0] i8;
    i8 = {1'b0, idx};
    case (code)
      CS_UPPER:  return 8'h41 + i8;
      CS_DIGIT:  return 8'h30 + i8;
      CS_LOWDIG: return (i8 < 8'd26) ? 8'h61 + i8 : 8'h30 + (i8 - 8'd26);
      CS_ALPHA:  return (i8 < 8'd26) ? 8'h61 + i8 : 8'h41 + (i8 - 8'd26);
      CS_ALNUM:  return (i8 < 8'd26) ? 8'h61 + i8 :
                        (i8 < 8'd52) ? 8'h41 + (i8 - 8'd26) : 8'h30 + (i8 - 8'd52);
      CS_PRINT:  return 8'h20 + i8;
      default:   return 8'h61 + i8;
    endcase
  endfunction

endpackage

// File: rtl/guess_digit.sv
// One odometer position: index register, wrap/carry and character lookup.
module guess_digit (
  input  logic       clk,
  input  logic       clear,
  input  logic       inc,
  input  logic [6:0] n,
  input  logic [2:0] code,
  output logic       carry,
  output logic       at_max,
  output logic [7:0] ch
);
  import guess_pkg::*;

  logic [6:0] idx;

  assign at_max = (idx == n - 7'd1);
  assign carry  = at_max & inc;
  assign ch     = cs_char(code, idx);

  always_ff @(posedge clk) begin
    if (clear)
      idx <= 7'd0;
    else if (inc)
      idx <= at_max ? 7'd0 : idx + 7'd1;
  end

endmodule

// File: rtl/guess_generator.sv
// Enumerates every string of the programmed length over the selected charset,
// one candidate per clock, then raises a sticky done.
module guess_generator #(
  parameter int MAXLEN = guess_pkg::MAXLEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            charset,
  input  logic [4:0]            guesslen,
  output logic [8*MAXLEN-1:0]   guess,
  output logic                  done
);
  import guess_pkg::*;

  logic [2:0]        code_q;
  logic [4:0]        len_q;
  logic [4:0]        len_clamped;
  logic [6:0]        n_size;
  logic [MAXLEN-1:0] active;
  logic [MAXLEN-1:0] at_max;
  logic              exhaust;
  logic              step;

  always_comb begin
    len_clamped = guesslen;
    if (guesslen == 5'd0)
      len_clamped = 5'd1;
    else if (guesslen > 5'(MAXLEN))
      len_clamped = 5'(MAXLEN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q <= charset;
      len_q  <= len_clamped;
      done   <= 1'b0;
    end else if (!done && exhaust) begin
      done <= 1'b1;
    end
  end

  always_comb begin
    active = '0;
    for (int i = 0; i < MAXLEN; i++)
      active[i] = (i < int'(len_q));
  end

  assign n_size  = cs_size(code_q);
  // Inactive positions count as saturated so only the first L digits decide.
  assign exhaust = &(at_max | ~active);
  assign step    = ~reset & ~done & ~exhaust;

  for (genvar i = 0; i < MAXLEN; i++) begin : g_digit
    logic       inc_d;
    logic       carry_d;
    logic [7:0] ch_d;

    if (i == 0) begin : g_first
      assign inc_d = step;
    end else begin : g_chain
      assign inc_d = g_digit[i-1].carry_d & active[i];
    end

    guess_digit u_digit (
      .clk    (clk),
      .clear  (reset),
      .inc    (inc_d),
      .n      (n_size),
      .code   (code_q),
      .carry  (carry_d),
      .at_max (at_max[i]),
      .ch     (ch_d)
    );

    assign guess[8*i +: 8] = active[i] ? ch_d : 8'h00;
  end

endmodule

// File: tb/tb_guess_generator.sv
// Scoreboard bench: stimulus queues expected candidates, a negedge monitor pops and compares.
module tb_guess_generator;

  typedef struct {
    logic [127:0] g;
    logic         d;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [2:0]   charset;
  logic [4:0]   guesslen;
  logic [127:0] guess;
  logic         done;

  exp_t q[$];
  logic mon_en;
  int   checks;
  int   errors;

  guess_generator dut (
    .clk      (clk),
    .reset    (reset),
    .charset  (charset),
    .guesslen (guesslen),
    .guess    (guess),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string cs_str(input int cs);
    string lo, up, dg, pr;
    lo = "abcdefghijklmnopqrstuvwxyz";
    up = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    dg = "0123456789";
    pr = "";
    for (int c = 32; c <= 126; c++) pr = {pr, string'(8'(c))};
    case (cs)
      1: return up;
      2: return dg;
      3: return {lo, dg};
      4: return {lo, up};
      5: return {lo, up, dg};
      6: return pr;
      default: return lo;
    endcase
  endfunction

  function automatic int eff_len(input int gl);
    if (gl == 0) return 1;
    if (gl > 16) return 16;
    return gl;
  endfunction

  // Expected output for the k-th cycle after reset release (k counts advances).
  function automatic exp_t model(input int cs, input int gl, input longint k);
    exp_t   e;
    string  s;
    int     n, len;
    longint total, r;
    s = cs_str(cs);
    n = s.len();
    len = eff_len(gl);
    total = 1;
    for (int i = 0; i < len; i++)
      if (total < 64'd1_000_000_000_000) total = total * n;
    e.d = (k >= total);
    r = e.d ? total - 1 : k;
    e.g = '0;
    for (int i = 0; i < len; i++) begin
      e.g[8*i +: 8] = s[int'(r % n)];
      r = r / n;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL underflow: DUT output guess=%h done=%b with no expected entry", guess, done);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (guess !== e.g || done !== e.d) begin
          errors++;
          $display("FAIL cand t=%0t: actual guess=%h done=%b required guess=%h done=%b",
                   $time, guess, done, e.g, e.d);
        end
      end
    end
  end

  // Hold reset for n edges; cycles after the first reset edge must show the first candidate.
  task automatic rst(input int cs, input int gl, input int n);
    mon_en   = 1'b0;
    reset    = 1'b1;
    charset  = 3'(cs);
    guesslen = 5'(gl);
    @(posedge clk); #1;
    for (int i = 1; i < n; i++) q.push_back(model(cs, gl, 0));
    if (n > 1) mon_en = 1'b1;
    repeat (n - 1) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  task automatic run(input int cs, input int gl, input longint k0, input int n, input bit fiddle);
    for (int i = 0; i < n; i++) q.push_back(model(cs, gl, k0 + i));
    mon_en = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      if (fiddle) begin
        charset  = 3'($urandom_range(0, 7));
        guesslen = 5'($urandom_range(0, 31));
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    mon_en   = 1'b0;
    reset    = 1'b1;
    charset  = 3'd0;
    guesslen = 5'd1;

    rst(2, 2, 1);  run(2, 2, 0, 112, 1'b1);   // 100 guesses, done, frozen hold
    rst(0, 1, 1);  run(0, 1, 0, 28, 1'b0);
    rst(2, 0, 1);  run(2, 0, 0, 12, 1'b0);
    rst(0, 20, 1); run(0, 20, 0, 30, 1'b0);
    rst(5, 1, 1);  run(5, 1, 0, 64, 1'b0);
    rst(7, 1, 1);  run(7, 1, 0, 28, 1'b0);
    rst(1, 3, 1);  run(1, 3, 0, 30, 1'b0);
    rst(3, 2, 1);  run(3, 2, 0, 40, 1'b0);
    rst(4, 2, 1);  run(4, 2, 0, 60, 1'b0);
    rst(6, 2, 1);  run(6, 2, 0, 200, 1'b0);
    rst(2, 3, 1);  run(2, 3, 0, 37, 1'b1);    // mid-run reset with charset switch
    rst(6, 3, 3);  run(6, 3, 0, 5, 1'b0);
    rst(2, 1, 1);  run(2, 1, 0, 21, 1'b0);    // done then 10 frozen cycles
    rst(2, 1, 2);  run(2, 1, 0, 3, 1'b0);

    mon_en = 1'b0;
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover: actual %0d pending entries, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
